// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the arb_rr_n arbiter slice.
//   arb_state_e    : two-state grant FSM (ARB_IDLE, ARB_OWNED)
//   ARB_MODE_FIXED : mode value selecting fixed priority (lowest index wins)
//   ARB_MODE_RR    : mode value selecting round robin from the pointer
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

endpackage : arb_pkg

// File: rtl/arb_rr_n_if.sv
// -----------------------------------------------------------------------------
// arb_rr_n_if
// Request/grant bundle between N bus masters and the arbiter.
//   req    : request vector, bit i = requester i
//   mode   : 0 = fixed priority, 1 = round robin
//   gnt    : registered one-hot grant (or all zero)
//   gnt_id : encoded index of the granted requester, 0 when idle
//   busy   : high while a grant is held
// Modports:
//   master : requester side (drives req/mode, observes grant)
//   slave  : arbiter side (observes req/mode, drives grant)
// -----------------------------------------------------------------------------
interface arb_rr_n_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic           mode;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;

  modport master (
    output req, mode,
    input  gnt, gnt_id, busy
  );

  modport slave (
    input  req, mode,
    output gnt, gnt_id, busy
  );

endinterface : arb_rr_n_if

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational rotating-priority picker.
//   req    in  N    candidate requests (owner already masked by the caller)
//   ptr    in  IDW  search start index used in round-robin mode
//   mode   in  1    ARB_MODE_FIXED searches from 0, ARB_MODE_RR from ptr
//   onehot out N    one-hot winner, all zero when nothing is requested
//   idx    out IDW  encoded winner index, 0 when nothing is requested
//   valid  out 1    at least one candidate request was present
// -----------------------------------------------------------------------------
module arb_pick
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           mode,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           valid
);

  // Walk the N positions starting at 'start' and wrapping past N-1; the first
  // set request wins. ptr is always kept below N by the caller, so one
  // subtraction is enough to wrap.
  always_comb begin
    int start;
    int cand;
    // NOTE: every output gets a default before the search so no path through
    // this block leaves a value unassigned, which would infer a latch.
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    start  = (mode == ARB_MODE_RR) ? int'(ptr) : 0;
    for (int i = 0; i < N; i++) begin
      cand = start + i;
      if (cand >= N) cand = cand - N;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IDW'(cand);
      end
    end
    if (valid) onehot = {{(N-1){1'b0}}, 1'b1} << idx;
  end

endmodule : arb_pick

// File: rtl/arb_rr_n.sv
// -----------------------------------------------------------------------------
// arb_rr_n
// N-requester arbiter with runtime-selectable fixed-priority or round-robin
// policy. A grant is held while its request stays high; when the owner drops,
// the next winner is granted on the same edge with no idle cycle in between.
//
// Ports:
//   clk    in  1   sole clock, rising edge
//   reset  in  1   asynchronous, active-low reset
//   bus    slave   arb_rr_n_if (req, mode in; gnt, gnt_id, busy out)
//
// Parameters:
//   N        number of requesters (>= 2)
//   MAX_HOLD maximum consecutive grant cycles before forced rotation (>= 1)
//
// Build option:
//   ARB_HOLD_LIMIT_EN  when defined, a hold counter forces the owner off after
//                      MAX_HOLD cycles if another requester is waiting. When
//                      undefined, no counter exists and grants are held for as
//                      long as the owner requests.
// -----------------------------------------------------------------------------
module arb_rr_n
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic     clk,
  input  logic     reset,
  arb_rr_n_if.slave bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           grant_new;

  logic [N-1:0]   pick_req;
  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] pick_idx;
  logic           pick_valid;

  logic           owner_req;
  logic           others_req;
  logic           force_off;

  assign owner_req  = |(bus.req & gnt_q);
  assign others_req = |(bus.req & ~gnt_q);

  // The current owner never competes in a re-arbitration: either it has
  // dropped its request already, or it is being forced off by the hold limit.
  // In IDLE gnt_q is zero, so the full request vector is visible.
  assign pick_req = bus.req & ~gnt_q;

  arb_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (pick_req),
    .ptr    (ptr_q),
    .mode   (bus.mode),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam int            HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;

  // Rotation is only forced when someone else is actually waiting; a sole
  // requester keeps the grant and the counter sits at HOLD_MAX.
  assign force_off = (state_q == ARB_OWNED) && (hold_q == HOLD_MAX) && others_req;

  always_comb begin
    hold_d = hold_q;
    if (grant_new)                 hold_d = HW'(1);
    else if (state_d == ARB_IDLE)  hold_d = '0;
    else if (hold_q != HOLD_MAX)   hold_d = hold_q + HW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign force_off = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register (FSM state plus the grant/pointer datapath it owns)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, regardless of statement order.
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    grant_new = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // An all-zero request leaves everything, including ptr, untouched.
        if (pick_valid) grant_new = 1'b1;
      end
      ARB_OWNED: begin
        // Owner still requesting and not forced off: hold, no re-arbitration.
        if (!owner_req || force_off) begin
          if (pick_valid) begin
            grant_new = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            id_d    = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase

    // Every new grant, in either mode, advances ptr past the winner so that
    // round robin stays fair after a mode switch.
    if (grant_new) begin
      state_d = ARB_OWNED;
      gnt_d   = pick_onehot;
      id_d    = pick_idx;
      ptr_d   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.gnt    = gnt_q;
    bus.gnt_id = id_q;
    bus.busy   = (state_q == ARB_OWNED);
  end

endmodule : arb_rr_n

// File: tb/tb_arb_rr_n.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_n
// Self-checking bench for arb_rr_n (N=4, MAX_HOLD=8). Directed table, a few
// multi-cycle sequences, then randomized traffic against a reference model.
// Honors ARB_HOLD_LIMIT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_arb_rr_n;
  import arb_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  arb_rr_n_if #(.N(N)) bus ();

  arb_rr_n #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] id;
  } vec_t;

  vec_t tbl [18];

  // Reference model state: owner index (-1 = idle), rotation pointer, hold age.
  int m_owner;
  int m_ptr;
  int m_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] exp_gnt, input logic [1:0] exp_id);
    check({name, ".gnt"},    32'(bus.gnt),    32'(exp_gnt));
    check({name, ".gnt_id"}, 32'(bus.gnt_id), 32'(exp_id));
    check({name, ".busy"},   32'(bus.busy),   32'(|exp_gnt));
  endtask

  // Drive inputs just after an edge, then observe just after the next edge.
  task automatic apply(input logic [3:0] r, input logic m);
    bus.req  = r;
    bus.mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  // One clock edge of the arbitration rules.
  task automatic model_step(input logic [N-1:0] r, input logic m);
    int others;
    int w;
    int i;
    others = 0;
    w      = -1;
    for (int k = 0; k < N; k++) if (k != m_owner && r[k]) others++;
    if (m_owner >= 0 && r[m_owner] &&
        !(HOLD_EN && m_hold >= MAX_HOLD && others > 0)) begin
      if (m_hold < MAX_HOLD) m_hold++;
      return;
    end
    for (int k = 0; k < N; k++) begin
      i = (m == ARB_MODE_RR) ? (m_ptr + k) % N : k;
      if (w < 0 && i != m_owner && r[i]) w = i;
    end
    if (w >= 0) begin
      m_owner = w;
      m_ptr   = (w + 1) % N;
      m_hold  = 1;
    end else begin
      m_owner = -1;
      m_hold  = 0;
    end
  endtask

  initial begin
    logic [3:0] r;
    logic       m;
    logic [3:0] exp_gnt;
    logic [1:0] exp_id;

    // req, mode, expected gnt, expected gnt_id (sequence starts from reset)
    tbl[0]  = '{4'b1010, 1'b0, 4'b0010, 2'd1};  // fixed: lowest index wins
    tbl[1]  = '{4'b1010, 1'b0, 4'b0010, 2'd1};  // held
    tbl[2]  = '{4'b1000, 1'b0, 4'b1000, 2'd3};  // owner drops -> direct handover
    tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};  // release -> idle
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};  // rr from ptr=0
    tbl[6]  = '{4'b1110, 1'b1, 4'b0010, 2'd1};
    tbl[7]  = '{4'b1101, 1'b1, 4'b0100, 2'd2};
    tbl[8]  = '{4'b1011, 1'b1, 4'b1000, 2'd3};
    tbl[9]  = '{4'b0111, 1'b1, 4'b0001, 2'd0};  // wrap back to 0
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
    tbl[11] = '{4'b1001, 1'b1, 4'b1000, 2'd3};  // ptr=1 -> 3 beats 0
    tbl[12] = '{4'b0001, 1'b0, 4'b0001, 2'd0};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    tbl[14] = '{4'b1000, 1'b0, 4'b1000, 2'd3};
    tbl[15] = '{4'b1001, 1'b0, 4'b1000, 2'd3};  // no preemption by higher priority
    tbl[16] = '{4'b0001, 1'b0, 4'b0001, 2'd0};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 2'd0};

    rst_n    = 1'b0;
    bus.req  = '0;
    bus.mode = ARB_MODE_FIXED;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- directed table ----
    for (int v = 0; v < 18; v++) begin
      apply(tbl[v].req, tbl[v].mode);
      check_out($sformatf("tbl[%0d]", v), tbl[v].gnt, tbl[v].id);
    end

    // ---- asynchronous reset mid-grant ----
    apply(4'b0110, ARB_MODE_FIXED);
    check_out("pre_reset", 4'b0010, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 4'b0000, 2'd0);
    @(posedge clk);
    #1;
    check_out("reset_held", 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_reset", 4'b0010, 2'd1);

    // ---- sole requester never loses the grant ----
    apply(4'b0000, ARB_MODE_RR);
    check_out("sole_idle", 4'b0000, 2'd0);
    for (int c = 0; c < 20; c++) begin
      apply(4'b0001, ARB_MODE_RR);
      check_out($sformatf("sole[%0d]", c), 4'b0001, 2'd0);
    end
    apply(4'b0000, ARB_MODE_RR);
    check_out("sole_done", 4'b0000, 2'd0);

    // ---- hold limit with a competing requester ----
    apply(4'b0001, ARB_MODE_RR);
    check_out("hold_first", 4'b0001, 2'd0);
    if (HOLD_EN) begin
      for (int c = 0; c < MAX_HOLD - 1; c++) begin
        apply(4'b0101, ARB_MODE_RR);
        check_out($sformatf("hold[%0d]", c), 4'b0001, 2'd0);
      end
      apply(4'b0101, ARB_MODE_RR);
      check_out("hold_forced", 4'b0100, 2'd2);
    end else begin
      for (int c = 0; c < 12; c++) begin
        apply(4'b0101, ARB_MODE_RR);
        check_out($sformatf("hold[%0d]", c), 4'b0001, 2'd0);
      end
      apply(4'b0100, ARB_MODE_RR);
      check_out("hold_release", 4'b0100, 2'd2);
    end
    apply(4'b0000, ARB_MODE_RR);
    check_out("hold_done", 4'b0000, 2'd0);

    // ---- mode switch while owned ----
    apply(4'b0100, ARB_MODE_FIXED);
    check_out("mode_own", 4'b0100, 2'd2);
    for (int c = 0; c < 3; c++) begin
      apply(4'b1111, ARB_MODE_RR);
      check_out($sformatf("mode_hold[%0d]", c), 4'b0100, 2'd2);
    end
    apply(4'b1011, ARB_MODE_RR);
    check_out("mode_next", 4'b1000, 2'd3);
    apply(4'b0000, ARB_MODE_FIXED);
    check_out("mode_done", 4'b0000, 2'd0);

    // ---- randomized traffic against the model ----
    bus.req = '0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    m = ARB_MODE_FIXED;
    for (int c = 0; c < 1500; c++) begin
      r = 4'($urandom);
      if ($urandom_range(0, 9) == 0) r = '0;
      if (m_owner >= 0 && $urandom_range(0, 9) < 7) r[m_owner] = 1'b1;
      if ($urandom_range(0, 7) == 0) m = ~m;
      apply(r, m);
      model_step(r, m);
      exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      exp_id  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      check_out($sformatf("rand[%0d]", c), exp_gnt, exp_id);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_arb_rr_n
